ftdi_cmd_parser: RTL and testbench

- Byte-level command framer/executor directly downstream of the FTDI controller.
- Receives bytes through the controller's interlocked RX handshake and decodes framed read/write commands. Writes and reads a simple register bus.
- Sends ACK/NAK and read-data bytes back through the controller's TX inputs.
- The host-side register access path of the FPGA.

---
 rtl/ftdi_cmd_parser.sv | 157 +++++++++++++++
 tb/tb_ftdi_cmd_parser.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ftdi_cmd_parser.sv
// rtl/ftdi_cmd_parser.sv - framed read/write command parser and register bus master behind the FTDI controller
module ftdi_cmd_parser #(
    parameter int   ADDR_W      = 8,
    parameter int   TIMEOUT_CYC = 65535,
    parameter logic [7:0] SOF   = 8'hA5
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic [7:0]        in_rx_data,
    input  logic              in_rx_prd_rdy,
    output logic              out_rx_cons_rdy,
    output logic              out_rx_ena,
    output logic [7:0]        out_tx_data,
    output logic              out_tx_data_rdy,
    input  logic              in_ftdi_wr,
    output logic              out_reg_we,
    output logic              out_reg_re,
    output logic [ADDR_W-1:0] out_reg_addr,
    output logic [7:0]        out_reg_wdata,
    input  logic [7:0]        in_reg_rdata,
    output logic [7:0]        out_err_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK,
        S_EXEC_WR, S_EXEC_RD, S_RDWAIT,
        S_TX_ACK, S_TX_DATA, S_TX_NAK
    } state_t;

    state_t            state, state_nxt;
    logic              armed;
    logic              wr_prev;
    logic [CNT_W-1:0]  to_cnt;
    logic [7:0]        cmd_q, addr_q, data_q, rdata_q;
    logic [7:0]        err_cnt;

    logic rx_state, in_frame, accept, sent, timeout_hit, chk_match, frame_ok, tx_state;

    assign rx_state    = (state == S_IDLE) || in_frame;
    assign in_frame    = (state == S_CMD) || (state == S_ADDR) ||
                         (state == S_DATA) || (state == S_CHK);
    assign tx_state    = (state == S_TX_ACK) || (state == S_TX_DATA) || (state == S_TX_NAK);
    assign accept      = in_rx_prd_rdy && armed && rx_state;
    assign sent        = tx_state && wr_prev && !in_ftdi_wr;
    assign timeout_hit = in_frame && !accept && (to_cnt == CNT_W'(TIMEOUT_CYC));
    assign chk_match   = in_rx_data == (cmd_q ^ addr_q ^ ((cmd_q == CMD_WR) ? data_q : 8'h00));
    assign frame_ok    = chk_match && ((cmd_q == CMD_WR) || (cmd_q == CMD_RD));

    // State register
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Next-state decode: frame walk, timeout abort, execution and transmit sequencing
    always_comb begin
        state_nxt = state;
        if (timeout_hit) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (accept && in_rx_data == SOF) state_nxt = S_CMD;
                S_CMD:     if (accept) state_nxt = S_ADDR;
                S_ADDR:    if (accept) state_nxt = (cmd_q == CMD_WR) ? S_DATA : S_CHK;
                S_DATA:    if (accept) state_nxt = S_CHK;
                S_CHK:     if (accept) state_nxt = !frame_ok ? S_TX_NAK :
                                                   (cmd_q == CMD_WR) ? S_EXEC_WR : S_EXEC_RD;
                S_EXEC_WR: state_nxt = S_TX_ACK;
                S_EXEC_RD: state_nxt = S_RDWAIT;
                S_RDWAIT:  state_nxt = S_TX_ACK;
                S_TX_ACK:  if (sent) state_nxt = (cmd_q == CMD_RD) ? S_TX_DATA : S_IDLE;
                S_TX_DATA: if (sent) state_nxt = S_IDLE;
                S_TX_NAK:  if (sent) state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode from state and the current-cycle accept
    always_comb begin
        out_rx_ena      = rx_state;
        out_rx_cons_rdy = accept;
        out_reg_we      = (state == S_EXEC_WR);
        out_reg_re      = (state == S_EXEC_RD);
        out_tx_data_rdy = tx_state;
        out_tx_data     = 8'h00;
        case (state)
            S_TX_ACK:  out_tx_data = ACK;
            S_TX_DATA: out_tx_data = rdata_q;
            S_TX_NAK:  out_tx_data = NAK;
            default:   out_tx_data = 8'h00;
        endcase
    end

    // Handshake interlock: one byte per prd_rdy assertion, WR history for falling-edge detect
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            armed   <= 1'b1;
            wr_prev <= 1'b0;
        end else begin
            wr_prev <= in_ftdi_wr;
            if (accept)              armed <= 1'b0;
            else if (!in_rx_prd_rdy) armed <= 1'b1;
        end
    end

    // Inter-byte timeout counter, only live while a frame is partially received
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n)                      to_cnt <= '0;
        else if (accept || !in_frame || timeout_hit) to_cnt <= '0;
        else                                to_cnt <= to_cnt + 1'b1;
    end

    // Frame field capture and read-data latch
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cmd_q   <= 8'h00;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            if (accept && state == S_CMD)  cmd_q  <= in_rx_data;
            if (accept && state == S_ADDR) addr_q <= in_rx_data;
            if (accept && state == S_DATA) data_q <= in_rx_data;
            if (state == S_RDWAIT)         rdata_q <= in_reg_rdata;
        end
    end

    // Register bus address/data only move on a validated frame so they hold between commands
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_reg_addr  <= '0;
            out_reg_wdata <= 8'h00;
        end else if (state == S_CHK && accept && frame_ok) begin
            out_reg_addr <= addr_q[ADDR_W-1:0];
            if (cmd_q == CMD_WR) out_reg_wdata <= data_q;
        end
    end

    // Saturating error counter for NAKed and timed-out frames
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            err_cnt <= 8'h00;
        end else if (((state == S_CHK && accept && !frame_ok) || timeout_hit) && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end

    assign out_err_cnt = err_cnt;

endmodule

// File: tb/tb_ftdi_cmd_parser.sv
// tb/tb_ftdi_cmd_parser.sv - directed self-checking bench for ftdi_cmd_parser
module tb_ftdi_cmd_parser;

    localparam int TO = 40;

    logic       clk, rst_n;
    logic [7:0] rx_data;
    logic       rx_prd_rdy, rx_cons_rdy, rx_ena;
    logic [7:0] tx_data;
    logic       tx_data_rdy, ftdi_wr;
    logic       reg_we, reg_re;
    logic [7:0] reg_addr, reg_wdata, reg_rdata, err_cnt;

    int n_checks = 0;
    int n_bad    = 0;
    int cons_cnt = 0, we_cnt = 0, re_cnt = 0, rdy_cycles = 0;
    logic [7:0] last_waddr = 0, last_wdata = 0, last_raddr = 0;

    ftdi_cmd_parser #(.ADDR_W(8), .TIMEOUT_CYC(TO), .SOF(8'hA5)) dut (
        .in_clk(clk), .in_rst_n(rst_n),
        .in_rx_data(rx_data), .in_rx_prd_rdy(rx_prd_rdy),
        .out_rx_cons_rdy(rx_cons_rdy), .out_rx_ena(rx_ena),
        .out_tx_data(tx_data), .out_tx_data_rdy(tx_data_rdy),
        .in_ftdi_wr(ftdi_wr),
        .out_reg_we(reg_we), .out_reg_re(reg_re),
        .out_reg_addr(reg_addr), .out_reg_wdata(reg_wdata),
        .in_reg_rdata(reg_rdata), .out_err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after posedge, so at negedge these reflect what the next posedge commits
    always @(negedge clk) begin
        if (rx_cons_rdy) cons_cnt++;
        if (reg_we) begin we_cnt++; last_waddr = reg_addr; last_wdata = reg_wdata; end
        if (reg_re) begin re_cnt++; last_raddr = reg_addr; end
        if (tx_data_rdy) rdy_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int extra_hold);
        logic got;
        got = 1'b0;
        rx_data = b;
        rx_prd_rdy = 1'b1;
        #1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (rx_cons_rdy) got = 1'b1;
            else cyc();
        end
        check_eq("rx_accept", {31'd0, got}, 32'd1);
        cyc();
        repeat (extra_hold) cyc();
        rx_prd_rdy = 1'b0;
        cyc();
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input logic [7:0] e, input int n);
        send_byte(a, 0); send_byte(b, 0); send_byte(c, 0); send_byte(d, 0);
        if (n == 5) send_byte(e, 0);
    endtask

    task automatic tx_expect(input string tag, input logic [7:0] exp, input int hold);
        logic stable;
        for (int k = 0; k < 30 && !tx_data_rdy; k++) cyc();
        check_eq({tag, "_rdy"}, {31'd0, tx_data_rdy}, 32'd1);
        check_eq({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp});
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            cyc();
            if (tx_data_rdy !== 1'b1 || tx_data !== exp) stable = 1'b0;
        end
        if (hold > 0) check_eq({tag, "_stable"}, {31'd0, stable}, 32'd1);
        ftdi_wr = 1'b1;
        cyc();
        ftdi_wr = 1'b0;
        cyc();
    endtask

    initial begin
        int c0, w0, r0, d0;
        rst_n = 1'b0; rx_data = 8'h00; rx_prd_rdy = 1'b0; ftdi_wr = 1'b0; reg_rdata = 8'h00;
        cyc(); cyc();
        check_eq("rst_rx_ena", {31'd0, rx_ena}, 32'd1);
        check_eq("rst_tx_rdy", {31'd0, tx_data_rdy}, 32'd0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check_eq("rst_err", {24'd0, err_cnt}, 32'd0);
        check_eq("rst_we_re_cons", {29'd0, reg_we, reg_re, rx_cons_rdy}, 32'd0);
        check_eq("rst_addr", {24'd0, reg_addr}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Write frame
        c0 = cons_cnt; w0 = we_cnt;
        send_frame(8'hA5, 8'h01, 8'h10, 8'h5C, 8'h4D, 5);
        tx_expect("wr_ack", 8'h06, 2);
        check_eq("wr_rdy_drop", {31'd0, tx_data_rdy}, 32'd0);
        check_eq("wr_cons_cnt", cons_cnt - c0, 32'd5);
        check_eq("wr_we_cnt", we_cnt - w0, 32'd1);
        check_eq("wr_addr", {24'd0, last_waddr}, 32'h10);
        check_eq("wr_wdata", {24'd0, last_wdata}, 32'h5C);
        check_eq("wr_idle_rx_ena", {31'd0, rx_ena}, 32'd1);

        // Read frame
        reg_rdata = 8'h9E; w0 = we_cnt; r0 = re_cnt;
        send_frame(8'hA5, 8'h02, 8'h22, 8'h20, 8'h00, 4);
        check_eq("rd_rx_ena_off", {31'd0, rx_ena}, 32'd0);
        tx_expect("rd_ack", 8'h06, 3);
        tx_expect("rd_data", 8'h9E, 3);
        check_eq("rd_rdy_drop", {31'd0, tx_data_rdy}, 32'd0);
        check_eq("rd_re_cnt", re_cnt - r0, 32'd1);
        check_eq("rd_addr", {24'd0, last_raddr}, 32'h22);
        check_eq("rd_no_we", we_cnt - w0, 32'd0);
        check_eq("rd_wdata_held", {24'd0, reg_wdata}, 32'h5C);

        // Bad checksum
        w0 = we_cnt;
        send_frame(8'hA5, 8'h01, 8'h10, 8'h5C, 8'h00, 5);
        tx_expect("bad_nak", 8'h15, 0);
        check_eq("bad_no_we", we_cnt - w0, 32'd0);
        check_eq("bad_err", {24'd0, err_cnt}, 32'd1);

        // Junk byte then stalled frame
        d0 = rdy_cycles;
        send_byte(8'h33, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        repeat (TO - 8) cyc();
        check_eq("to_not_yet", {24'd0, err_cnt}, 32'd1);
        repeat (20) cyc();
        check_eq("to_err", {24'd0, err_cnt}, 32'd2);
        check_eq("to_idle_rx_ena", {31'd0, rx_ena}, 32'd1);
        check_eq("to_no_tx", rdy_cycles - d0, 32'd0);

        // Held prd_rdy consumes once; then a valid write with TX held off
        c0 = cons_cnt; w0 = we_cnt;
        send_byte(8'hA5, 3);
        check_eq("hold_one_cons", cons_cnt - c0, 32'd1);
        send_byte(8'h01, 0); send_byte(8'h33, 0); send_byte(8'h44, 0); send_byte(8'h76, 0);
        tx_expect("after_ack", 8'h06, 50);
        check_eq("after_we_cnt", we_cnt - w0, 32'd1);
        check_eq("after_addr", {24'd0, last_waddr}, 32'h33);
        check_eq("after_wdata", {24'd0, last_wdata}, 32'h44);
        check_eq("after_err", {24'd0, err_cnt}, 32'd2);

        // Asynchronous reset in the middle of TX_DATA
        send_frame(8'hA5, 8'h02, 8'h22, 8'h20, 8'h00, 4);
        tx_expect("rst_ack", 8'h06, 0);
        check_eq("pre_rst_rdy", {31'd0, tx_data_rdy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_rdy", {31'd0, tx_data_rdy}, 32'd0);
        check_eq("arst_data", {24'd0, tx_data}, 32'h00);
        cyc();
        rst_n = 1'b1;
        cyc();
        check_eq("post_rst_rx_ena", {31'd0, rx_ena}, 32'd1);
        check_eq("post_rst_err", {24'd0, err_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
